// File: rtl/clb_pkg.sv
// Shared types and field-layout helpers for the clb_cluster logic cluster.
package clb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ACTIVE
  } clb_state_e;

  function automatic int unsigned clb_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  function automatic int unsigned ble_bits(input int unsigned k, input int unsigned sw);
    return 2 + k * sw + (1 << k);
  endfunction

  // Per-BLE field offsets within the configuration chain; j selects the BLE.
  function automatic int unsigned outsel_off(input int unsigned j, input int unsigned bb);
    return j * bb;
  endfunction

  function automatic int unsigned init_off(input int unsigned j, input int unsigned bb);
    return j * bb + 1;
  endfunction

  function automatic int unsigned sel_off(input int unsigned j, input int unsigned k,
                                          input int unsigned bb, input int unsigned sw);
    return j * bb + 2 + k * sw;
  endfunction

  function automatic int unsigned lut_off(input int unsigned j, input int unsigned kin,
                                          input int unsigned bb, input int unsigned sw);
    return j * bb + 2 + kin * sw;
  endfunction

endpackage

// File: rtl/clb_ble.sv
// Basic logic element: input crossbar, K-input LUT, user FF and output mux.
module clb_ble
  import clb_pkg::*;
#(
  parameter int unsigned K = 4,
  parameter int unsigned N = 4,
  parameter int unsigned I = 10,
  localparam int unsigned SW = clb_clog2(I + N),
  localparam int unsigned BB = ble_bits(K, SW)
) (
  input  logic          prog_clk,
  input  logic          rst,
  input  logic [BB-1:0] cfg,
  input  logic [N-1:0]  fb,
  input  logic [I-1:0]  clb_in,
  input  logic          load_init,
  input  logic          ff_en,
  output logic          q,
  output logic          out
);

  logic              out_sel;
  logic              init;
  logic [(1<<SW)-1:0] src;
  logic [K-1:0]      addr;
  logic [(1<<K)-1:0] tbl;
  logic              lut;

  assign out_sel = cfg[outsel_off(0, BB)];
  assign init    = cfg[init_off(0, BB)];
  assign tbl     = cfg[lut_off(0, K, BB, SW) +: (1 << K)];

  // Selects beyond I+N land on the zero padding of src.
  always_comb begin
    src = '0;
    src[I+N-1:0] = {fb, clb_in};
    addr = '0;
    for (int unsigned k = 0; k < K; k++) begin
      addr[k] = src[cfg[sel_off(0, k, BB, SW) +: SW]];
    end
  end

  assign lut = tbl[addr];

  always_ff @(posedge prog_clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (load_init) begin
      q <= init;
    end else if (ff_en) begin
      q <= lut;
    end
  end

  assign out = out_sel ? lut : q;

endmodule

// File: rtl/clb_cluster.sv
// Logic cluster of N BLEs configured through a serial shift chain.
// Define CLB_PARITY_EN to append an even-parity bit to the chain.
module clb_cluster
  import clb_pkg::*;
#(
  parameter int unsigned K = 4,
  parameter int unsigned N = 4,
  parameter int unsigned I = 10
) (
  input  logic         prog_clk,
  input  logic         rst,
  input  logic         prog_en,
  input  logic         prog_in,
  output logic         prog_out,
  input  logic         clb_ce,
  input  logic [I-1:0] clb_in,
  output logic [N-1:0] clb_out,
  output logic         cfg_done,
  output logic         cfg_err
);

  localparam int unsigned SW       = clb_clog2(I + N);
  localparam int unsigned BLE_BITS = ble_bits(K, SW);
  localparam int unsigned CFG_BITS = N * BLE_BITS;
`ifdef CLB_PARITY_EN
  localparam int unsigned CHAIN    = CFG_BITS + 1;
`else
  localparam int unsigned CHAIN    = CFG_BITS;
`endif
  localparam int unsigned CW       = clb_clog2(CHAIN + 2);
  localparam logic [CW-1:0] CHAIN_C = CW'(CHAIN);
  localparam logic [CW-1:0] CNT_MAX = CW'(CHAIN + 1);

  clb_state_e       state;
  logic [CHAIN-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             par_ok;
  logic             cfg_ok;
  logic             load_init;
  logic             ff_en;
  logic             active;
  logic [N-1:0]     q;
  logic [N-1:0]     ble_out;

  always_ff @(posedge prog_clk) begin
    if (!rst) begin
      sr <= '0;
    end else if (prog_en) begin
      sr <= {prog_in, sr[CHAIN-1:1]};
    end
  end

  assign prog_out = sr[0];

`ifdef CLB_PARITY_EN
  logic par;

  // The entry cycle restarts the accumulator with the first shifted bit.
  always_ff @(posedge prog_clk) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (prog_en) begin
      par <= (state == ST_SHIFT) ? (par ^ prog_in) : prog_in;
    end
  end

  assign par_ok = ~par;
`else
  assign par_ok = 1'b1;
`endif

  assign cfg_ok = (cnt == CHAIN_C) && par_ok;

  always_ff @(posedge prog_clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACTIVE: begin
          if (prog_en) begin
            state    <= ST_SHIFT;
            cnt      <= CW'(1);
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (prog_en) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end else if (cfg_ok) begin
            state    <= ST_ACTIVE;
            cfg_done <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            cfg_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign active    = (state == ST_ACTIVE) && !prog_en;
  assign load_init = (state == ST_SHIFT) && !prog_en && cfg_ok;
  assign ff_en     = active && clb_ce;

  for (genvar j = 0; j < N; j++) begin : g_ble
    clb_ble #(
      .K(K),
      .N(N),
      .I(I)
    ) u_ble (
      .prog_clk (prog_clk),
      .rst      (rst),
      .cfg      (sr[outsel_off(j, BLE_BITS) +: BLE_BITS]),
      .fb       (q),
      .clb_in   (clb_in),
      .load_init(load_init),
      .ff_en    (ff_en),
      .q        (q[j]),
      .out      (ble_out[j])
    );
  end

  assign clb_out = active ? ble_out : '0;

endmodule

// File: tb/tb_clb_cluster.sv
// Directed self-checking bench for clb_cluster at default parameters.
module tb_clb_cluster;

  localparam int CFG = 136;
`ifdef CLB_PARITY_EN
  localparam int CHAIN = CFG + 1;
`else
  localparam int CHAIN = CFG;
`endif

  logic       prog_clk = 1'b0;
  logic       rst;
  logic       prog_en;
  logic       prog_in;
  logic       prog_out;
  logic       clb_ce;
  logic [9:0] clb_in;
  logic [3:0] clb_out;
  logic       cfg_done;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  logic [CHAIN:0] stream;
  logic [CHAIN:0] bad;
  logic [CHAIN:0] obs;
  logic [3:0]     or_out;

  clb_cluster #(.K(4), .N(4), .I(10)) dut (
    .prog_clk(prog_clk),
    .rst     (rst),
    .prog_en (prog_en),
    .prog_in (prog_in),
    .prog_out(prog_out),
    .clb_ce  (clb_ce),
    .clb_in  (clb_in),
    .clb_out (clb_out),
    .cfg_done(cfg_done),
    .cfg_err (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] o, input logic [191:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Shifts n bits of v (LSB first), recording prog_out and clb_out before each edge.
  task automatic shift_bits(input logic [CHAIN:0] v, input int n);
    obs = '0;
    or_out = '0;
    for (int i = 0; i < n; i++) begin
      prog_en = 1'b1;
      prog_in = v[i];
      #1;
      obs[i] = prog_out;
      or_out = or_out | clb_out;
      @(posedge prog_clk);
      #1;
    end
    prog_en = 1'b0;
    prog_in = 1'b0;
  endtask

  initial begin
    stream = '0;
    stream[0]      = 1'b1;          // BLE0 out_sel = LUT
    stream[9:6]    = 4'd1;          // BLE0 in1 = clb_in[1]
    stream[13:10]  = 4'd15;
    stream[17:14]  = 4'd15;
    stream[33:18]  = 16'h8888;      // in0 & in1
    stream[35]     = 1'b1;          // BLE1 init
    stream[39:36]  = 4'd11;         // BLE1 in0 = own FF
    stream[51:40]  = 12'hFFF;
    stream[67:52]  = 16'h5555;      // ~in0
`ifdef CLB_PARITY_EN
    stream[CFG] = ^stream[CFG-1:0];
`endif

    rst = 1'b0; prog_en = 1'b0; prog_in = 1'b0; clb_ce = 1'b0; clb_in = '0;
    tick(); tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 50; i++) begin
      prog_en = 1'b1; prog_in = 1'b1;
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1; prog_en = 1'b0; prog_in = 1'b0;
    tick();
    check("rst_prog_out", prog_out, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_clb_out", clb_out, 0);

    shift_bits(stream, CHAIN);
    tick();
    check("load_done", cfg_done, 1);
    check("load_err", cfg_err, 0);
    check("load_prog_out", prog_out, 1);

    clb_in = 10'd3; #1;
    check("and_11", clb_out, 4'b0011);
    clb_in = 10'd1; #1;
    check("and_01", clb_out, 4'b0010);

    clb_ce = 1'b1;
    tick();
    check("toggle_1", clb_out, 4'b0000);
    tick();
    check("toggle_2", clb_out, 4'b0010);
    clb_ce = 1'b0;
    tick(); tick();
    check("hold_ce0", clb_out, 4'b0010);

    clb_in = 10'd3; #1;
    check("pre_reload", clb_out, 4'b0011);
    shift_bits(stream, CHAIN - 1);
    check("reload_gated", or_out, 0);
    check("reload_prog_out", obs[CHAIN-2:0], stream[CHAIN-2:0]);
    tick();
    check("short_err", cfg_err, 1);
    check("short_done", cfg_done, 0);
    check("short_clb_out", clb_out, 0);
    tick(); tick();
    check("err_sticky", cfg_err, 1);

    shift_bits(stream, CHAIN + 1);
    tick();
    check("long_err", cfg_err, 1);
    check("long_done", cfg_done, 0);
    check("long_clb_out", clb_out, 0);

    shift_bits(stream, CHAIN);
    tick();
    check("reload_done", cfg_done, 1);
    check("reload_err_clr", cfg_err, 0);
    check("reload_init", clb_out, 4'b0011);

`ifdef CLB_PARITY_EN
    bad = stream;
    bad[CFG] = ~bad[CFG];
    shift_bits(bad, CHAIN);
    tick();
    check("par_bad_err", cfg_err, 1);
    check("par_bad_done", cfg_done, 0);
    shift_bits(stream, CHAIN);
    tick();
    check("par_ok_done", cfg_done, 1);
    check("par_ok_err", cfg_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
